// File: rtl/grid_spi_target_if.sv
// grid_spi_target_if: SPI bus lines between controller and target
interface grid_spi_target_if;
  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  modport master (output sclk, ss_n, mosi, input miso);
  modport slave (input sclk, ss_n, mosi, output miso);
endinterface

// File: rtl/grid_spi_target.sv
// grid_spi_target: SPI mode-0 target returning one playfield row per read command
module grid_spi_target #(
  parameter int NUM_ROWS = 20,
  parameter int ROW_W = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_ROWS*ROW_W-1:0] grid_state,
  grid_spi_target_if.slave          spi,
  output logic                      cmd_valid,
  output logic [7:0]                cmd_byte,
  output logic                      busy
);
  typedef enum logic [2:0] {IDLE, CMD, DATA_HI, DATA_LO, DONE} state_t;
  state_t state, state_n;
  logic [1:0] sclk_s, ss_s, mosi_s;
  logic sclk_q, ss_q;
  logic [2:0] bit_cnt;
  logic [7:0] rx, tx, cmd_next;
  logic [15:0] word, word_next;
  logic [ROW_W-1:0] row_bits;
  logic row_ok, sclk_rise, sclk_fall, ss_fall, ss_high, byte_done;
  always_comb begin
    sclk_rise = sclk_s[1] & ~sclk_q;
    sclk_fall = ~sclk_s[1] & sclk_q;
    ss_fall = ~ss_s[1] & ss_q;
    ss_high = ss_s[1];
    byte_done = sclk_rise && bit_cnt == 3'd7 && !ss_high;
    cmd_next = {rx[6:0], mosi_s[1]};
    row_bits = '0;
    row_ok = 1'b0;
    for (int i = 0; i < NUM_ROWS; i++)
      if (cmd_next[4:0] == 5'(i)) begin
        row_bits = grid_state[i*ROW_W +: ROW_W];
        row_ok = 1'b1;
      end
    word_next = !cmd_next[7] ? 16'h0000 : row_ok ? 16'(row_bits) : 16'hFFFF;
    state_n = state;
    if (state == IDLE) state_n = ss_fall ? CMD : IDLE;
    else if (ss_high) state_n = IDLE;
    else if (byte_done) state_n = state == CMD ? DATA_HI : state == DATA_HI ? DATA_LO : DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // ss_n deassertion outranks a coincident SCLK edge, so that bit is dropped
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sclk_s <= '0;
      ss_s <= '0;
      mosi_s <= '0;
      sclk_q <= 1'b0;
      ss_q <= 1'b0;
      bit_cnt <= '0;
      rx <= '0;
      tx <= '0;
      word <= '0;
      cmd_valid <= 1'b0;
      cmd_byte <= '0;
    end else begin
      sclk_s <= {sclk_s[0], spi.sclk};
      ss_s <= {ss_s[0], spi.ss_n};
      mosi_s <= {mosi_s[0], spi.mosi};
      sclk_q <= sclk_s[1];
      ss_q <= ss_s[1];
      cmd_valid <= state == CMD && byte_done;
      if (state == CMD && byte_done) begin
        cmd_byte <= cmd_next;
        word <= word_next;
      end
      if (state == IDLE || ss_high) begin
        bit_cnt <= '0;
        rx <= '0;
        tx <= '0;
      end else begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (state == CMD) rx <= cmd_next;
        end
        if (sclk_fall)
          tx <= bit_cnt != 3'd0 ? {tx[6:0], 1'b0} :
                state == DATA_HI ? word[15:8] : state == DATA_LO ? word[7:0] : 8'h00;
      end
    end
  assign spi.miso = tx[7] & ~spi.ss_n;
endmodule

// File: tb/tb_grid_spi_target.sv
// tb_grid_spi_target: directed SPI transfers against hand-computed row words
module tb_grid_spi_target;
  logic clk = 1'b0;
  logic reset_n;
  logic [199:0] grid_state;
  logic cmd_valid, busy;
  logic [7:0] cmd_byte;
  logic [7:0] r0, r1, r2, r3, r4;
  int n_cmp = 0, n_err = 0, pulses = 0, p0;
  grid_spi_target_if spi();
  grid_spi_target dut (.clk(clk), .reset_n(reset_n), .grid_state(grid_state), .spi(spi),
                       .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) if (cmd_valid === 1'b1) pulses++;
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic sbit(input logic b, output logic m);
    spi.mosi = b;
    wclk(8);
    spi.sclk = 1'b1;
    m = spi.miso;
    wclk(8);
    spi.sclk = 1'b0;
  endtask
  task automatic sbyte(input logic [7:0] d, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) sbit(d[i], r[i]);
  endtask
  task automatic start();
    spi.ss_n = 1'b0;
    wclk(8);
  endtask
  task automatic stop();
    wclk(8);
    spi.ss_n = 1'b1;
    wclk(8);
  endtask
  initial begin
    reset_n = 1'b0;
    spi.sclk = 1'b0;
    spi.ss_n = 1'b1;
    spi.mosi = 1'b0;
    grid_state = '0;
    wclk(4);
    chk("rst_miso", 32'(spi.miso), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_cmd_byte", 32'(cmd_byte), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    wclk(4);
    grid_state[39:30] = 10'h2A5;
    p0 = pulses;
    start();
    chk("busy_high", 32'(busy), 1);
    sbyte(8'h83, r0); sbyte(8'h00, r1); sbyte(8'h00, r2);
    stop();
    chk("row3_b0", 32'(r0), 32'h00);
    chk("row3_b1", 32'(r1), 32'h02);
    chk("row3_b2", 32'(r2), 32'hA5);
    chk("row3_cmd", 32'(cmd_byte), 32'h83);
    chk("row3_pulses", 32'(pulses - p0), 1);
    chk("row3_busy_low", 32'(busy), 0);
    start(); sbyte(8'h94, r0); sbyte(8'h00, r1); sbyte(8'h00, r2); stop();
    chk("row20_b1", 32'(r1), 32'hFF);
    chk("row20_b2", 32'(r2), 32'hFF);
    start(); sbyte(8'h9F, r0); sbyte(8'h00, r1); sbyte(8'h00, r2); stop();
    chk("row31_b1", 32'(r1), 32'hFF);
    chk("row31_b2", 32'(r2), 32'hFF);
    start(); sbyte(8'h15, r0); sbyte(8'hFF, r1); sbyte(8'hFF, r2); sbyte(8'hFF, r3); stop();
    chk("nonread_cmd", 32'(cmd_byte), 32'h15);
    chk("nonread_bytes", {r0, r1, r2, r3}, 32'h0);
    grid_state[199:190] = 10'h1C6;
    start(); sbyte(8'hF3, r0); sbyte(8'h00, r1); sbyte(8'h00, r2); sbyte(8'h00, r3); sbyte(8'h00, r4); stop();
    chk("row19_word", {16'h0, r1, r2}, 32'h01C6);
    chk("row19_overrun", {16'h0, r3, r4}, 32'h0);
    grid_state[9:0] = 10'h3FF;
    start(); sbyte(8'h80, r0);
    grid_state[9:0] = 10'h000;
    sbyte(8'h00, r1); sbyte(8'h00, r2); stop();
    chk("snap_word", {16'h0, r1, r2}, 32'h03FF);
    p0 = pulses;
    start();
    for (int i = 0; i < 5; i++) sbit(1'b1, r0[0]);
    spi.ss_n = 1'b1;
    chk("abort_miso", 32'(spi.miso), 0);
    wclk(8);
    chk("abort_pulses", 32'(pulses - p0), 0);
    chk("abort_cmd", 32'(cmd_byte), 32'h80);
    chk("abort_busy", 32'(busy), 0);
    start(); sbyte(8'h83, r0); sbyte(8'h00, r1); sbyte(8'h00, r2); stop();
    chk("after_abort_word", {8'h0, r0, r1, r2}, 32'h0002A5);
    start(); sbyte(8'h83, r0);
    sbit(1'b0, r1[7]); sbit(1'b0, r1[6]);
    chk("pre_rst_miso", 32'(spi.miso), 0);
    sbit(1'b0, r1[5]);
    chk("pre_rst_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", {22'h0, spi.miso, cmd_valid, cmd_byte}, 32'h0);
    chk("rst_mid_busy", 32'(busy), 0);
    wclk(3);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) sbit(1'b0, r1[i]);
    chk("post_rst_ignored_busy", 32'(busy), 0);
    chk("post_rst_ignored_cmd", 32'(cmd_byte), 0);
    stop();
    start(); sbyte(8'h83, r0); sbyte(8'h00, r1); sbyte(8'h00, r2); stop();
    chk("post_rst_word", {8'h0, r0, r1, r2}, 32'h0002A5);
    chk("post_rst_cmd", 32'(cmd_byte), 32'h83);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/grid_spi_target.md
# grid_spi_target

SPI target (slave) that lets an external SPI controller read the 200-bit Tetris playfield one row at a time. It is the responder-side counterpart of the system's SPI controller interface (SCLK/MOSI/MISO/SS_n) and sits beside the grid producer, sampling `grid_state`. It oversamples the SPI lines in the system clock domain, decodes a one-byte command, and returns a 16-bit row word MSB first.

## Interface
- `NUM_ROWS`, 20, number of playfield rows.
- `ROW_W`, 10, cells per row; `grid_state` width is `NUM_ROWS*ROW_W`.
- `clk`  in  1  system clock; must be at least 8x the SCLK frequency.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `grid_state`  in  200  playfield; row r is `grid_state[r*10 +: 10]`, bit 0 = leftmost cell.
- `sclk`  in  1  SPI clock from controller, mode 0 (CPOL=0, CPHA=0).
- `ss_n`  in  1  target select, active-low.
- `mosi`  in  1  controller-to-target data, MSB first.
- `miso`  out  1  target-to-controller data, MSB first; 0 whenever `ss_n` is high.
- `cmd_valid`  out  1  one-clk pulse when a command byte completes.
- `cmd_byte`  out  8  last completed command byte; held until the next one.
- `busy`  out  1  high from `ss_n` assertion until deassertion.

## Operation
- `sclk`, `ss_n`, `mosi` pass through 2-flop synchronizers; edges are detected on the synchronized `sclk` (rise = sample, fall = shift).
- FSM states: IDLE, CMD, DATA_HI, DATA_LO, DONE.
- IDLE -> CMD on synchronized `ss_n` falling; the 3-bit bit counter clears and the tx shift register loads 0x00.
- CMD: each rise shifts `mosi` into the rx register. On the 8th rise, `cmd_byte` updates, `cmd_valid` pulses, and the state moves to DATA_HI.
- Read command is bit7=1, with row = bits 4:0 and bits 6:5 ignored. On command completion, the 16-bit word is snapshotted as `{6'b0, grid_state[row*10 +: 10]}`. If row >= `NUM_ROWS`, the word is 16'hFFFF.
- A non-read command (bit7=0) snapshots 16'h0000.
- DATA_HI transmits word[15:8], then DATA_LO transmits word[7:0], then the FSM enters DONE. DONE shifts out 0x00 for any further bytes and ignores `mosi`.
- `ss_n` deassertion in any state returns the FSM to IDLE, clears the bit counter, and drives `miso` to 0. A partial command byte does not produce `cmd_valid`, and `cmd_byte` is unchanged.
- Reset values: `miso`=0, `cmd_valid`=0, `cmd_byte`=0x00, `busy`=0, FSM=IDLE, and all shift registers and synchronizers 0.
- Reset asserted mid-transfer forces the reset values immediately. After reset release, the FSM stays in IDLE until a fresh `ss_n` falling edge; a transfer already in progress is ignored.

## Timing
- Synchronizer plus edge detect: an SCLK edge is acted on 3 clk after it occurs.
- `miso` updates on the clk following a detected SCLK fall. The controller samples on SCLK rise, so each bit is stable for at least half an SCLK period minus 4 clk.
- The first data bit (word[15]) is presented after the 8th command SCLK fall, before the 9th rise.
- `cmd_valid` is high exactly 1 clk, 3 clk after the 8th SCLK rise.
- The `grid_state` snapshot is taken in that same cycle. Later changes to `grid_state` do not affect the word in flight.
- `busy` rises/falls 3 clk after `ss_n` falls/rises.
- Simultaneous events:
  - A detected `ss_n` rise in the same clk as an SCLK rise: `ss_n` wins, and the bit is discarded.
  - SCLK edges while `ss_n` is high: ignored.

## Test plan
- Read valid row: set row 3 = 10'h2A5 (`grid_state[39:30]`), then transfer 0x83 followed by 2 dummy bytes. Required: `cmd_valid` pulses once, `cmd_byte`=0x83, and MISO bytes are 0x00, 0x02, 0xA5.
- Row out of range: transfer 0x94 (row 20) followed by 2 bytes. Required: MISO returns 0xFF, 0xFF. Transfer 0x9F: also 0xFF, 0xFF.
- Non-read command and overrun: transfer 0x15 followed by 3 bytes. Required: `cmd_byte`=0x15, and every MISO byte is 0x00. Then read row 19 with 4 trailing bytes: the bytes are the row word, then 0x00, 0x00.
- Snapshot: read row 0 = 10'h3FF, and change it to 10'h000 right after `cmd_valid`. Required: MISO returns 0x03, 0xFF.
- Abort: raise `ss_n` after 5 command bits. Required: no `cmd_valid`, `cmd_byte` unchanged, `miso`=0, `busy` falls. The next full read of row 3 returns the correct value.
- Reset mid-transfer: pulse `reset_n` low during DATA_HI. Required: all outputs return to reset values at once, and the next transfer succeeds.
